async_fifo_core: RTL and testbench
==================================

// Module: async_fifo_core
// PURPOSE
//  Dual-port FIFO queue (Gray-coded pointer architecture) carrying commands/data between producer and consumer logic.
//  Used by the Hyperbus FIFO bridge for command (R/W bit + address), TX and RX queues.
//  First-word-fall-through: head word is always presented on rdata while not empty.
//  Full/empty plus almost-full/almost-empty flags.
// PARAMETERS
//  DSIZE  8  data word width in bits (Hyperbus bridge uses 33 and 32)
//  ASIZE  4  address bits; depth DEPTH = 2**ASIZE words (bridge uses 2 -> 4 words)
// PORTS
//  clk      in   1      single clock; all logic on posedge clk
//  rst_n    in   1      reset, asynchronous assert, active-low
//  winc     in   1      write strobe; pushes wdata when !wfull
//  wdata    in   DSIZE  write data
//  wfull    out  1      FIFO holds DEPTH words
//  awfull   out  1      almost full: occupancy >= DEPTH-1
//  rinc     in   1      read strobe; pops head when !rempty
//  rdata    out  DSIZE  head word (show-ahead, combinational from storage)
//  rempty   out  1      FIFO holds 0 words
//  arempty  out  1      almost empty: occupancy <= 1
// BEHAVIOUR
//  Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//  Reset: wptr=rptr=0, rempty=1, arempty=1, wfull=0, awfull=0; storage not reset, rdata undefined until first write.
//  Pointers ASIZE+1 bits binary, mirrored in Gray; MSB distinguishes wrap. Memory indexed by ptr[ASIZE-1:0].
//  Write: winc && !wfull -> mem[wptr]<=wdata, wptr++ on that edge. winc while full ignored, no corruption.
//  Read: rinc && !rempty -> rptr++ on that edge; rdata then shows next word combinationally.
//  rinc while empty ignored. Flags sampled on the edge gate the strobes (registered flag values, not next-state).
//  Simultaneous winc+rinc, neither blocked: both happen, occupancy unchanged, flags unchanged.
//  Full & winc&rinc: read happens, write dropped. Empty & winc&rinc: write happens, read dropped.
//  Flags registered, computed from next-state pointers: a write into empty FIFO clears rempty on the same edge
//  (rdata valid the following cycle); a read from full clears wfull on the same edge.
//  rempty = (rgray_next == wgray); wfull = (wgray_next == {~rgray[MSB:MSB-1], rgray[MSB-2:0]}).
//  Occupancy = wptr - rptr, modulo 2**(ASIZE+1); awfull/arempty derived from it, registered.
//  Wrap-around: pointers roll over freely; occupancy arithmetic is modulo, no saturation.
//  Reset mid-operation: immediately empties FIFO, flags return to reset values asynchronously.
// CONFIGURATION
//  ASYNC_FIFO_SYNC_EN defined: Gray pointers cross through 2-flop synchronizers (w->r, r->w) before flag compare.
//   Flags become conservative: rempty deasserts 3 cycles after the write edge; wfull deasserts 3 cycles after read edge.
//   awfull/arempty likewise use synced pointers. Never reports non-empty/non-full falsely.
//  Undefined (default): flags compare local pointers directly, timing as in BEHAVIOUR.
// STRUCTURE
//  Package async_fifo_pkg: function bin2gray, function gray2bin, localparam helpers PTR_W(ASIZE)=ASIZE+1.
//  Sub-module async_fifo_mem: DEPTH x DSIZE storage, sync write port, async read port.
//  Top holds pointer/flag logic and (when enabled) the synchronizer flops.
// TESTING (DSIZE=33, ASIZE=2, macro undefined unless noted)
//  Reset -> rempty=1, arempty=1, wfull=0, awfull=0.
//  Write 0x1_0000_0040 once -> next cycle rempty=0, arempty=1, rdata=0x1_0000_0040; rinc -> rempty=1.
//  Write 0x1,0x2,0x3,0x4 -> awfull after 3rd, wfull after 4th; 5th write 0x5 dropped; reads return 1,2,3,4 then empty.
//  Full + simultaneous winc(0x9)/rinc -> head pops, 0x9 dropped; empty + winc/rinc -> 0x9 stored, rempty=0.
//  Stream 20 words interleaved (wraps pointers 2x) -> read order identical, no flag glitches.
//  With ASYNC_FIFO_SYNC_EN: single write -> rempty falls exactly 3 cycles later; assert rst_n=0 mid-stream -> flags reset immediately.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - pointer-width helper and Gray/binary conversions for async_fifo_core
package async_fifo_pkg;

  localparam int MAX_PTR_W = 16;

  function automatic int ptr_w(input int asize);
    return asize + 1;
  endfunction

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// rtl/async_fifo_mem.sv - DEPTH x DSIZE FIFO storage, synchronous write, asynchronous read
module async_fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  // Storage is deliberately not reset; content is only meaningful behind the pointers.
  logic [DSIZE-1:0] r_mem [0:(1<<ASIZE)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/async_fifo_core.sv
// rtl/async_fifo_core.sv - Gray-pointer FWFT FIFO with full/empty and almost flags
// Optional: ASYNC_FIFO_SYNC_EN routes Gray pointers through 2-flop synchronizers before flag compare.
module async_fifo_core
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty
);

  localparam int PTR_W = ptr_w(ASIZE);
  localparam int DEPTH = 1 << ASIZE;

  typedef logic [PTR_W-1:0] ptr_t;

  // Full when the write pointer leads by exactly DEPTH: top two Gray bits inverted.
  localparam ptr_t FULL_MASK = ptr_t'(3) << (PTR_W - 2);

  function automatic ptr_t to_gray(input ptr_t b);
    logic [MAX_PTR_W-1:0] t;
    t = bin2gray(MAX_PTR_W'(b));
    return t[PTR_W-1:0];
  endfunction

  function automatic ptr_t to_bin(input ptr_t g);
    logic [MAX_PTR_W-1:0] t;
    t = gray2bin(MAX_PTR_W'(g));
    return t[PTR_W-1:0];
  endfunction

  ptr_t r_wbin;
  ptr_t r_rbin;
  logic r_wfull;
  logic r_awfull;
  logic r_rempty;
  logic r_arempty;

  logic w_wr_en;
  logic w_rd_en;
  ptr_t w_wbin_next;
  ptr_t w_rbin_next;
  ptr_t w_wgray_next;
  ptr_t w_rgray_next;
  ptr_t w_wocc_next;
  ptr_t w_rocc_next;
  logic w_wfull_next;
  logic w_rempty_next;

  assign w_wr_en      = winc && !r_wfull;
  assign w_rd_en      = rinc && !r_rempty;
  assign w_wbin_next  = r_wbin + ptr_t'(w_wr_en);
  assign w_rbin_next  = r_rbin + ptr_t'(w_rd_en);
  assign w_wgray_next = to_gray(w_wbin_next);
  assign w_rgray_next = to_gray(w_rbin_next);

`ifdef ASYNC_FIFO_SYNC_EN
  ptr_t r_wgray;
  ptr_t r_rgray;
  ptr_t r_wq1_gray;
  ptr_t r_wq2_gray;
  ptr_t r_rq1_gray;
  ptr_t r_rq2_gray;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wgray    <= '0;
      r_rgray    <= '0;
      r_wq1_gray <= '0;
      r_wq2_gray <= '0;
      r_rq1_gray <= '0;
      r_rq2_gray <= '0;
    end else begin
      r_wgray    <= w_wgray_next;
      r_rgray    <= w_rgray_next;
      r_wq1_gray <= r_wgray;
      r_wq2_gray <= r_wq1_gray;
      r_rq1_gray <= r_rgray;
      r_rq2_gray <= r_rq1_gray;
    end
  end

  // Each side sees a stale view of the other, so flags err toward empty/full.
  assign w_rempty_next = (w_rgray_next == r_wq2_gray);
  assign w_wfull_next  = (w_wgray_next == (r_rq2_gray ^ FULL_MASK));
  assign w_wocc_next   = w_wbin_next - to_bin(r_rq2_gray);
  assign w_rocc_next   = to_bin(r_wq2_gray) - w_rbin_next;
`else
  assign w_rempty_next = (w_rgray_next == w_wgray_next);
  assign w_wfull_next  = (w_wgray_next == (w_rgray_next ^ FULL_MASK));
  assign w_wocc_next   = w_wbin_next - w_rbin_next;
  assign w_rocc_next   = w_wocc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin    <= '0;
      r_rbin    <= '0;
      r_wfull   <= 1'b0;
      r_awfull  <= 1'b0;
      r_rempty  <= 1'b1;
      r_arempty <= 1'b1;
    end else begin
      r_wbin    <= w_wbin_next;
      r_rbin    <= w_rbin_next;
      r_wfull   <= w_wfull_next;
      r_awfull  <= (w_wocc_next >= ptr_t'(DEPTH - 1));
      r_rempty  <= w_rempty_next;
      r_arempty <= (w_rocc_next <= ptr_t'(1));
    end
  end

  assign wfull   = r_wfull;
  assign awfull  = r_awfull;
  assign rempty  = r_rempty;
  assign arempty = r_arempty;

  async_fifo_mem #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_wr_en),
    .i_waddr(r_wbin[ASIZE-1:0]),
    .i_wdata(wdata),
    .i_raddr(r_rbin[ASIZE-1:0]),
    .o_rdata(rdata)
  );

endmodule

// File: tb/tb_async_fifo_core.sv
// tb/tb_async_fifo_core.sv - queue-model bench for async_fifo_core (DSIZE=33, ASIZE=2)
// Under ASYNC_FIFO_SYNC_EN only the synchronizer latency and reset scenarios are exercised.
module tb_async_fifo_core;

  localparam int DSIZE = 33;
  localparam int ASIZE = 2;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             winc = 1'b0;
  logic             rinc = 1'b0;
  logic [DSIZE-1:0] wdata = '0;
  logic             wfull;
  logic             awfull;
  logic             rempty;
  logic             arempty;
  logic [DSIZE-1:0] rdata;

  int total = 0;
  int bad = 0;

  logic [DSIZE-1:0] q[$];
  int m_n;

  async_fifo_core #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .winc   (winc),
    .wdata  (wdata),
    .wfull  (wfull),
    .awfull (awfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty),
    .arempty(arempty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic [DSIZE-1:0] d, input logic r);
    winc  = w;
    wdata = d;
    rinc  = r;
    @(posedge clk);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  function automatic logic [DSIZE-1:0] word(input int i);
    return 33'h1_0000_0000 | (DSIZE'(i) * 33'h101);
  endfunction

  // Occupancy model: strobes are gated by the occupancy before the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_n = q.size();
      if (rinc && m_n > 0) void'(q.pop_front());
      if (winc && m_n < DEPTH) q.push_back(wdata);
    end
  end

`ifndef ASYNC_FIFO_SYNC_EN
  always @(negedge clk) begin
    if (!rst_n) begin
      check("m_rst_rempty", rempty, 1);
      check("m_rst_wfull", wfull, 0);
    end else begin
      check("m_rempty", rempty, q.size() == 0);
      check("m_wfull", wfull, q.size() == DEPTH);
      check("m_awfull", awfull, q.size() >= DEPTH - 1);
      check("m_arempty", arempty, q.size() <= 1);
      if (q.size() != 0) check("m_rdata", rdata, q[0]);
    end
  end
`endif

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bit sw;
    bit sr;
    bit acc;
    int nw;
    int np;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rempty", rempty, 1);
    check("rst_arempty", arempty, 1);
    check("rst_wfull", wfull, 0);
    check("rst_awfull", awfull, 0);
    rst_n = 1'b1;
    step(0, '0, 0);

`ifdef ASYNC_FIFO_SYNC_EN
    step(1, 33'h1_0000_0040, 0);
    check("sync_e0_rempty", rempty, 1);
    step(0, '0, 0);
    check("sync_e1_rempty", rempty, 1);
    step(0, '0, 0);
    check("sync_e2_rempty", rempty, 1);
    step(0, '0, 0);
    check("sync_e3_rempty", rempty, 0);
    check("sync_rdata", rdata, 33'h1_0000_0040);
    step(0, '0, 1);
`else
    step(1, 33'h1_0000_0040, 0);
    check("one_rempty", rempty, 0);
    check("one_arempty", arempty, 1);
    check("one_rdata", rdata, 33'h1_0000_0040);
    step(0, '0, 1);
    check("one_pop_rempty", rempty, 1);

    for (int i = 1; i <= 4; i++) begin
      step(1, DSIZE'(i), 0);
      if (i == 3) begin
        check("fill3_awfull", awfull, 1);
        check("fill3_wfull", wfull, 0);
      end
    end
    check("fill4_wfull", wfull, 1);
    step(1, 33'h5, 0);
    check("drop5_wfull", wfull, 1);
    for (int i = 1; i <= 4; i++) begin
      check("drain_rdata", rdata, 64'(i));
      step(0, '0, 1);
    end
    check("drain_rempty", rempty, 1);

    for (int i = 1; i <= 4; i++) step(1, DSIZE'(i), 0);
    step(1, 33'h9, 1);
    check("fullrw_wfull", wfull, 0);
    check("fullrw_awfull", awfull, 1);
    check("fullrw_rdata", rdata, 33'h2);
    for (int i = 2; i <= 4; i++) begin
      check("fullrw_drain", rdata, 64'(i));
      step(0, '0, 1);
    end
    check("fullrw_empty", rempty, 1);
    step(1, 33'h9, 1);
    check("emptyrw_rempty", rempty, 0);
    check("emptyrw_rdata", rdata, 33'h9);
    step(0, '0, 1);

    nw = 0;
    np = 0;
    for (int cyc = 0; cyc < 200 && !(nw == 20 && np == 20); cyc++) begin
      sw  = (nw < 20) && (cyc % 4 != 3);
      sr  = (cyc % 3 != 0);
      acc = sw && (q.size() < DEPTH);
      if (sr && q.size() > 0) begin
        check("stream_order", rdata, word(np));
        np++;
      end
      step(sw, word(nw), sr);
      if (acc) nw++;
    end
    check("stream_words", 64'(nw), 20);
    check("stream_pops", 64'(np), 20);
`endif

    for (int i = 0; i < 3; i++) step(1, word(i), 0);
    repeat (4) step(0, '0, 0);
    check("midrst_pre_rempty", rempty, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rempty", rempty, 1);
    check("midrst_arempty", arempty, 1);
    check("midrst_wfull", wfull, 0);
    check("midrst_awfull", awfull, 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, '0, 0);
    check("postrst_rempty", rempty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
